stopwatch_ctrl: RTL

- Upstream time source for the six-digit seven-segment display path. Produces a MM:SS.hh stopwatch count as six BCD digits, plus a decimal-point mask, for the per-digit decoders and the scan stage.
- Three raw push-buttons control it: start/stop, clear and lap.
- Debouncing, the run/pause/lap state machine and the cascaded BCD counting all live inside this block.

---
 rtl/stopwatch_pkg.sv | 53 +++++
 rtl/key_debounce.sv | 53 +++++
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.hh stopwatch front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam int NUM_DIGITS = 6;
  localparam int DIG_W      = 4;

  localparam logic [3:0] DIG_MAX_DEC  = 4'd9;
  localparam logic [3:0] DIG_MAX_SEXT = 4'd5;

  // Points after the seconds-units and minutes-units digits (active-low).
  localparam logic [5:0] DP_MASK_N = 6'b101011;

  // LSB position of each digit nibble inside the 24-bit count.
  localparam int HUN_U_LSB = 0;
  localparam int HUN_T_LSB = 4;
  localparam int SEC_U_LSB = 8;
  localparam int SEC_T_LSB = 12;
  localparam int MIN_U_LSB = 16;
  localparam int MIN_T_LSB = 20;

  // Highest value a digit may hold before it rolls over; only the
  // seconds-tens digit is base six.
  function automatic logic [3:0] digit_limit(input int lsb);
    logic [3:0] lim;
    case (lsb)
      HUN_U_LSB, HUN_T_LSB, SEC_U_LSB,
      MIN_U_LSB, MIN_T_LSB: lim = DIG_MAX_DEC;
      SEC_T_LSB:            lim = DIG_MAX_SEXT;
      default:              lim = DIG_MAX_DEC;
    endcase
    return lim;
  endfunction

  // One BCD increment: returns {carry_out, next_digit}.
  function automatic logic [4:0] digit_step(input logic [3:0] digit,
                                            input logic [3:0] max_val);
    logic [4:0] res;
    if (digit == max_val) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, digit + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser plus level debouncer for one active-low push-button.
// Emits a single-cycle pulse on each qualified press (1 -> 0 of the
// debounced level). A key already held when reset is released is not
// reported until it has been seen released once.
module key_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          armed_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser, stability counter and press-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      level_r     <= 1'b1;
      armed_r     <= 1'b0;
      cnt_r       <= CNT_ZERO;
      press_pulse <= 1'b0;
    end else begin
      sync1_r     <= key_n;
      sync2_r     <= sync1_r;
      armed_r     <= armed_r | sync2_r;
      press_pulse <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r     <= sync2_r;
          cnt_r       <= CNT_ZERO;
          press_pulse <= armed_r & ~sync2_r;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= CNT_ZERO;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch time source: three debounced keys drive a run/pause/lap
// state machine, a prescaler produces hundredths ticks, and a cascaded
// BCD chain holds MM:SS.hh for the seven-segment display path.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TICK_HZ     = 100,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start_n,
  input  logic        key_clr_n,
  input  logic        key_lap_n,
  output logic [23:0] bcd_out,
  output logic [5:0]  dp_n,
  output logic        running,
  output logic        overflow
);

  localparam int TICK_DIV  = CLK_FREQ / TICK_HZ;
  localparam int DB_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  logic          start_ev_s;
  logic          clr_ev_s;
  logic          lap_ev_s;
  sw_state_e     state_r;
  logic [PW-1:0] presc_r;
  logic          active_s;
  logic          tick_s;
  logic          clear_s;
  logic          lap_capture_s;
  logic [23:0]   count_r;
  logic [23:0]   count_nxt_s;
  logic [23:0]   lap_r;
  logic          wrap_s;
  logic          carry_s;
  logic [4:0]    step_s;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .key_n(key_start_n), .press_pulse(start_ev_s)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .rst(rst), .key_n(key_clr_n), .press_pulse(clr_ev_s)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .key_n(key_lap_n), .press_pulse(lap_ev_s)
  );

  // Tick generation: the prescaler only advances while the watch runs.
  always_comb begin
    active_s = (state_r == RUN) || (state_r == LAP);
    tick_s   = active_s && (presc_r == PRESC_LAST);
  end

  // Event qualification: start wins, so clr/lap act only when start is absent.
  always_comb begin
    clear_s       = 1'b0;
    lap_capture_s = 1'b0;
    case (state_r)
      RUN:     lap_capture_s = !start_ev_s && lap_ev_s;
      PAUSE:   clear_s       = !start_ev_s && clr_ev_s;
      default: begin
        clear_s       = 1'b0;
        lap_capture_s = 1'b0;
      end
    endcase
  end

  // Cascaded BCD increment; carry out of the top digit marks a wrap.
  always_comb begin
    count_nxt_s = count_r;
    carry_s     = tick_s;
    step_s      = 5'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step_s = digit_step(count_r[i*DIG_W +: DIG_W], digit_limit(i*DIG_W));
      if (carry_s) begin
        count_nxt_s[i*DIG_W +: DIG_W] = step_s[3:0];
        carry_s = step_s[4];
      end else begin
        carry_s = 1'b0;
      end
    end
    wrap_s = carry_s;
  end

  // Control state machine with registered running flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      running <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ev_s) begin
            state_r <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_ev_s) begin
            state_r <= PAUSE;
            running <= 1'b0;
          end else if (lap_ev_s) begin
            state_r <= LAP;
            running <= 1'b1;
          end
        end
        LAP: begin
          if (start_ev_s) begin
            state_r <= PAUSE;
            running <= 1'b0;
          end else if (lap_ev_s) begin
            state_r <= RUN;
            running <= 1'b1;
          end
        end
        PAUSE: begin
          if (start_ev_s) begin
            state_r <= RUN;
            running <= 1'b1;
          end else if (clr_ev_s) begin
            state_r <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler, live count, lap register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r  <= PRESC_ZERO;
      count_r  <= 24'd0;
      lap_r    <= 24'd0;
      overflow <= 1'b0;
    end else if (clear_s) begin
      presc_r  <= PRESC_ZERO;
      count_r  <= 24'd0;
      lap_r    <= 24'd0;
      overflow <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (tick_s) begin
        presc_r <= PRESC_ZERO;
      end else if (active_s) begin
        presc_r <= presc_r + PRESC_ONE;
      end
      if (wrap_s) begin
        overflow <= 1'b1;
      end
      if (lap_capture_s) begin
        lap_r <= count_r;
      end
    end
  end

  // Display registers: frozen lap value in LAP, otherwise the live count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out <= 24'd0;
      dp_n    <= DP_MASK_N;
    end else begin
      bcd_out <= (state_r == LAP) ? lap_r : count_r;
      dp_n    <= DP_MASK_N;
    end
  end

endmodule
